// File: rtl/video_timing_pattern.sv
// Video timing generator with a built-in pattern source (bars, checkerboard,
// gradient, solid fill). Every output is registered one cycle after the counters.
module video_timing_pattern #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int C_bits     = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                  clk_pixel,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [2:0]            pattern_sel,
    input  logic [3*C_bits-1:0]   fill_rgb,
    output logic [C_bits-1:0]     vga_r,
    output logic [C_bits-1:0]     vga_g,
    output logic [C_bits-1:0]     vga_b,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_blank,
    output logic                  frame_start,
    output logic [15:0]           frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = $clog2(BAR_W + 1);
    localparam int EXT_W   = (C_bits > 32) ? C_bits : 32;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [2:0]    pat;

    logic              h_last, v_last, origin_p0, active_p0, hsync_on_p0, vsync_on_p0;
    logic [2:0]        cur_pat_p0;
    logic [C_bits-1:0] r_p0, g_p0, b_p0;

    function automatic logic [C_bits-1:0] rail(input logic on);
        return {C_bits{on}};
    endfunction

    function automatic logic [C_bits-1:0] chan(input logic [EXT_W-1:0] v);
        return v[C_bits-1:0];
    endfunction

    function automatic logic check_bit(input logic [EXT_W-1:0] v);
        return v[CHECK_LOG2];
    endfunction

    assign h_last    = (hcnt == HW'(H_TOTAL - 1));
    assign v_last    = (vcnt == VW'(V_TOTAL - 1));
    assign origin_p0 = (hcnt == '0) && (vcnt == '0);

    // Stage 0: raster counters, bar tracker and per-frame pattern latch
    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            hcnt        <= '0;
            vcnt        <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            pat         <= '0;
            frame_count <= '0;
        end else if (enable) begin
            if (origin_p0) pat <= pattern_sel;
            if (h_last) begin
                hcnt    <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                if (v_last) begin
                    vcnt        <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    vcnt <= vcnt + VW'(1);
                end
            end else begin
                hcnt <= hcnt + HW'(1);
                if (bar_cnt == BW'(BAR_W - 1)) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + BW'(1);
                end
            end
        end
    end

    // Pixel (0,0) already uses the newly requested pattern.
    always_comb begin
        active_p0   = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
        hsync_on_p0 = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
        vsync_on_p0 = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
        cur_pat_p0  = origin_p0 ? pattern_sel : pat;
        r_p0 = '0;
        g_p0 = '0;
        b_p0 = '0;
        case (cur_pat_p0)
            3'd1: begin
                r_p0 = rail(~bar_idx[1]);
                g_p0 = rail(~bar_idx[2]);
                b_p0 = rail(~bar_idx[0]);
            end
            3'd2: begin
                r_p0 = rail(check_bit(EXT_W'(hcnt)) ^ check_bit(EXT_W'(vcnt)));
                g_p0 = r_p0;
                b_p0 = r_p0;
            end
            3'd3: begin
                r_p0 = chan(EXT_W'(hcnt));
                g_p0 = chan(EXT_W'(vcnt));
                b_p0 = chan(EXT_W'(frame_count));
            end
            3'd4: begin
                r_p0 = fill_rgb[3*C_bits-1:2*C_bits];
                g_p0 = fill_rgb[2*C_bits-1:C_bits];
                b_p0 = fill_rgb[C_bits-1:0];
            end
            default: ;
        endcase
        if (!active_p0) begin
            r_p0 = '0;
            g_p0 = '0;
            b_p0 = '0;
        end
    end

    // Stage 1: registered video outputs, blanked while reset or paused
    always_ff @(posedge clk_pixel) begin
        if (!resetn || !enable) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= ~H_SYNC_POL;
            vga_vsync   <= ~V_SYNC_POL;
            vga_blank   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= r_p0;
            vga_g       <= g_p0;
            vga_b       <= b_p0;
            vga_hsync   <= hsync_on_p0 ? H_SYNC_POL : ~H_SYNC_POL;
            vga_vsync   <= vsync_on_p0 ? V_SYNC_POL : ~V_SYNC_POL;
            vga_blank   <= ~active_p0;
            frame_start <= origin_p0;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern.sv
// Directed bench for video_timing_pattern using a small 80x47 raster
// (64x40 active) so whole frames run quickly.
module tb_video_timing_pattern;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 3, VB = 2;
    localparam int HT = 80, VT = 47, FRAME = HT * VT;

    logic        clk_pixel = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  pattern_sel = 3'd0;
    logic [23:0] fill_rgb = 24'h0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_blank, frame_start;
    logic [15:0] frame_count;
    logic [23:0] rgb;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    video_timing_pattern #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .C_bits(8), .CHECK_LOG2(5)
    ) dut (
        .clk_pixel(clk_pixel), .resetn(resetn), .enable(enable),
        .pattern_sel(pattern_sel), .fill_rgb(fill_rgb),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    task automatic wait_fs();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 100; i++) begin
            step(1);
            if (frame_start) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL wait_frame_start timeout got=0 exp=1"); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; pattern_sel = 3'd1;
        step(2);
        n_cmp++; if (vga_blank !== 1'b1) begin n_fail++; $display("FAIL rst_blank got=%b exp=1", vga_blank); end
        n_cmp++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL rst_rgb got=%h exp=000000", rgb); end
        n_cmp++; if ({vga_hsync, vga_vsync} !== 2'b11) begin n_fail++; $display("FAIL rst_sync got=%b exp=11", {vga_hsync, vga_vsync}); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
        n_cmp++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL rst_fc got=%h exp=0000", frame_count); end
        resetn = 1'b1;
        step(1);
        n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rel_fs got=%b exp=1", frame_start); end
        n_cmp++; if (vga_blank !== 1'b0) begin n_fail++; $display("FAIL rel_blank got=%b exp=0", vga_blank); end
        n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL rel_rgb got=%h exp=FFFFFF", rgb); end
        step(1);
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_width got=%b exp=0", frame_start); end
    endtask

    task automatic test_timing();
        int hl = 0, vl = 0, al = 0, fsn = 0;
        logic [15:0] fc0;
        wait_fs();
        fc0 = frame_count;
        for (int i = 0; i < FRAME; i++) begin
            if (!vga_hsync) hl++;
            if (!vga_vsync) vl++;
            if (!vga_blank) al++;
            if (frame_start) fsn++;
            step(1);
        end
        n_cmp++; if (hl != HS * VT) begin n_fail++; $display("FAIL hsync_low got=%0d exp=%0d", hl, HS * VT); end
        n_cmp++; if (vl != VS * HT) begin n_fail++; $display("FAIL vsync_low got=%0d exp=%0d", vl, VS * HT); end
        n_cmp++; if (al != HA * VA) begin n_fail++; $display("FAIL active_px got=%0d exp=%0d", al, HA * VA); end
        n_cmp++; if (fsn != 1) begin n_fail++; $display("FAIL fs_per_frame got=%0d exp=1", fsn); end
        n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL fs_period got=%b exp=1", frame_start); end
        n_cmp++; if (frame_count !== fc0 + 16'd1) begin n_fail++; $display("FAIL fc_inc got=%h exp=%h", frame_count, fc0 + 16'd1); end
    endtask

    task automatic test_bars();
        wait_fs();
        n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL bar_px0 got=%h exp=FFFFFF", rgb); end
        step(8);
        n_cmp++; if (rgb !== 24'hFFFF00) begin n_fail++; $display("FAIL bar_px8 got=%h exp=FFFF00", rgb); end
        step(8);
        n_cmp++; if (rgb !== 24'h00FFFF) begin n_fail++; $display("FAIL bar_px16 got=%h exp=00FFFF", rgb); end
        step(24);
        n_cmp++; if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL bar_px40 got=%h exp=FF0000", rgb); end
        step(23);
        n_cmp++; if ({vga_blank, rgb} !== 25'h0) begin n_fail++; $display("FAIL bar_px63 got=%b/%h exp=0/000000", vga_blank, rgb); end
        step(1);
        n_cmp++; if ({vga_blank, rgb} !== {1'b1, 24'h0}) begin n_fail++; $display("FAIL bar_px64 got=%b/%h exp=1/000000", vga_blank, rgb); end
        step(3);
        n_cmp++; if (vga_hsync !== 1'b1) begin n_fail++; $display("FAIL hs_px67 got=%b exp=1", vga_hsync); end
        step(1);
        n_cmp++; if (vga_hsync !== 1'b0) begin n_fail++; $display("FAIL hs_px68 got=%b exp=0", vga_hsync); end
        step(8);
        n_cmp++; if (vga_hsync !== 1'b1) begin n_fail++; $display("FAIL hs_px76 got=%b exp=1", vga_hsync); end
    endtask

    task automatic test_pattern_switch();
        wait_fs();
        step(10 * HT);
        pattern_sel = 3'd2;
        step(8);
        n_cmp++; if (rgb !== 24'hFFFF00) begin n_fail++; $display("FAIL sw_midframe got=%h exp=FFFF00", rgb); end
        wait_fs();
        n_cmp++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL chk_0_0 got=%h exp=000000", rgb); end
        step(32);
        n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL chk_32_0 got=%h exp=FFFFFF", rgb); end
        step(32 * HT);
        n_cmp++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL chk_32_32 got=%h exp=000000", rgb); end
        step(HT - 32);
        n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL chk_0_33 got=%h exp=FFFFFF", rgb); end
    endtask

    task automatic test_gradient_enable();
        int t0;
        logic [15:0] fc;
        pattern_sel = 3'd3;
        wait_fs();
        t0 = cyc; fc = frame_count;
        n_cmp++; if (rgb !== {16'h0, fc[7:0]}) begin n_fail++; $display("FAIL grad_0_0 got=%h exp=%h", rgb, {16'h0, fc[7:0]}); end
        step(5);
        n_cmp++; if (rgb !== {16'h0500, fc[7:0]}) begin n_fail++; $display("FAIL grad_5_0 got=%h exp=%h", rgb, {16'h0500, fc[7:0]}); end
        step(3 * HT);
        n_cmp++; if (rgb !== {16'h0503, fc[7:0]}) begin n_fail++; $display("FAIL grad_5_3 got=%h exp=%h", rgb, {16'h0503, fc[7:0]}); end
        step(5 + 2 * HT);
        n_cmp++; if (rgb !== {16'h0A05, fc[7:0]}) begin n_fail++; $display("FAIL grad_10_5 got=%h exp=%h", rgb, {16'h0A05, fc[7:0]}); end
        enable = 1'b0;
        step(1);
        n_cmp++; if ({vga_blank, vga_hsync, vga_vsync, frame_start} !== 4'b1110) begin n_fail++; $display("FAIL dis_ctrl got=%b exp=1110", {vga_blank, vga_hsync, vga_vsync, frame_start}); end
        n_cmp++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL dis_rgb got=%h exp=000000", rgb); end
        step(49);
        n_cmp++; if ({vga_blank, frame_count} !== {1'b1, fc}) begin n_fail++; $display("FAIL dis_hold got=%b/%h exp=1/%h", vga_blank, frame_count, fc); end
        enable = 1'b1;
        step(1);
        n_cmp++; if ({vga_blank, rgb} !== {1'b0, 16'h0B05, fc[7:0]}) begin n_fail++; $display("FAIL resume got=%b/%h exp=0/%h", vga_blank, rgb, {16'h0B05, fc[7:0]}); end
        wait_fs();
        n_cmp++; if (cyc - t0 != FRAME + 50) begin n_fail++; $display("FAIL paused_period got=%0d exp=%0d", cyc - t0, FRAME + 50); end
        fc = fc + 16'd1;
        n_cmp++; if (rgb !== {16'h0, fc[7:0]}) begin n_fail++; $display("FAIL grad_next got=%h exp=%h", rgb, {16'h0, fc[7:0]}); end
    endtask

    task automatic test_fill();
        pattern_sel = 3'd4; fill_rgb = 24'h123456;
        wait_fs();
        n_cmp++; if (rgb !== 24'h123456) begin n_fail++; $display("FAIL fill_a got=%h exp=123456", rgb); end
        fill_rgb = 24'hABCDEF;
        step(1);
        n_cmp++; if (rgb !== 24'hABCDEF) begin n_fail++; $display("FAIL fill_b got=%h exp=ABCDEF", rgb); end
        pattern_sel = 3'd5;
        wait_fs();
        n_cmp++; if ({vga_blank, rgb} !== 25'h0) begin n_fail++; $display("FAIL pat5 got=%b/%h exp=0/000000", vga_blank, rgb); end
    endtask

    task automatic test_reset_mid();
        pattern_sel = 3'd3;
        wait_fs();
        step(100 + 3 * HT);
        resetn = 1'b0;
        step(1);
        n_cmp++; if ({vga_blank, vga_hsync, vga_vsync, frame_start} !== 4'b1110) begin n_fail++; $display("FAIL mrst_ctrl got=%b exp=1110", {vga_blank, vga_hsync, vga_vsync, frame_start}); end
        n_cmp++; if ({rgb, frame_count} !== 40'h0) begin n_fail++; $display("FAIL mrst_data got=%h/%h exp=000000/0000", rgb, frame_count); end
        pattern_sel = 3'd2; resetn = 1'b1;
        step(1);
        n_cmp++; if ({frame_start, vga_blank, rgb} !== {2'b10, 24'h0}) begin n_fail++; $display("FAIL mrst_first got=%b%b/%h exp=10/000000", frame_start, vga_blank, rgb); end
        step(32);
        n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL mrst_chk got=%h exp=FFFFFF", rgb); end
    endtask

    task automatic test_wrap();
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        wait_fs();
        n_cmp++; if (frame_count !== 16'h0000) begin n_fail++; $display("FAIL fc_wrap got=%h exp=0000", frame_count); end
        wait_fs();
        n_cmp++; if (frame_count !== 16'h0001) begin n_fail++; $display("FAIL fc_after_wrap got=%h exp=0001", frame_count); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_pattern_switch();
        test_gradient_enable();
        test_fill();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_pattern.md
VIDEO_TIMING_PATTERN -- requirements
Module: video_timing_pattern

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line; multiple of 8.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch/sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch/sync widths in lines.
REQ-005 SHALL have parameters H_SYNC_POL/V_SYNC_POL, default 0/0, sync active level (0 = active-low).
REQ-006 SHALL have parameter C_bits, default 8, bits per colour channel (≤ 8 is not required; any ≥ 1).
REQ-007 SHALL have parameter CHECK_LOG2, default 5, log2 of checkerboard square size.
REQ-008 clk_pixel  input  1  pixel clock; one clock domain; all state updates on its rising edge.
REQ-009 resetn  input  1  synchronous, active-low reset.
REQ-010 enable  input  1  1 = timing runs; 0 = counters freeze, outputs forced blank.
REQ-011 pattern_sel  input  3  pattern request, sampled only at frame start.
REQ-012 fill_rgb  input  3*C_bits  solid-fill colour {r,g,b}.
REQ-013 vga_r, vga_g, vga_b  output  C_bits each  pixel colour.
REQ-014 vga_hsync, vga_vsync, vga_blank  output  1 each  syncs (per polarity params), blank = 1 outside active area.
REQ-015 frame_start  output  1  one-cycle pulse coincident with output pixel (0,0).
REQ-016 frame_count  output  16  completed-frame counter.

Function
REQ-017 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; hcnt counts 0..H_TOTAL-1, vcnt 0..V_TOTAL-1.
REQ-018 hcnt SHALL increment each enabled cycle; at H_TOTAL-1 wrap to 0 and advance vcnt; vcnt at V_TOTAL-1 wraps to 0.
REQ-019 active = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE); vga_blank = not active.
REQ-020 hsync asserted (at H_SYNC_POL level) for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC; vsync same rule on vcnt with V params.
REQ-021 All outputs SHALL be registered, exactly 1 cycle after the counter state they decode; syncs, blank, rgb, frame_start mutually aligned.
REQ-022 Active pattern register SHALL load pattern_sel only when hcnt=0 and vcnt=0 are decoded; mid-frame changes have no effect until next frame.
REQ-023 Pattern 0: black. Pattern 1: 8 colour bars, each H_ACTIVE/8 wide, left→right white, yellow, cyan, green, magenta, red, blue, black (channels all-ones or zero); bar index from a bar-width counter, no divider.
REQ-024 Pattern 2: checkerboard, white when hcnt[CHECK_LOG2] XOR vcnt[CHECK_LOG2] = 1, else black.
REQ-025 Pattern 3: gradient r = low C_bits of hcnt, g = low C_bits of vcnt, b = low C_bits of frame_count (zero-extended if C_bits > counter width).
REQ-026 Pattern 4: solid fill_rgb, sampled every pixel. Patterns 5-7: black.
REQ-027 rgb SHALL be all-zero whenever vga_blank = 1, regardless of pattern.
REQ-028 frame_count SHALL increment by 1 when vcnt and hcnt both wrap; 0xFFFF wraps to 0x0000.
REQ-029 enable = 0: hcnt, vcnt, frame_count, active pattern hold; next cycle vga_blank = 1, rgb = 0, syncs inactive, frame_start = 0; enable re-asserted resumes from held counts.
REQ-030 frame_start SHALL pulse once per frame, high for exactly one cycle, never while enable = 0.

Reset
REQ-031 resetn = 0 at a clock edge SHALL set hcnt = vcnt = 0, frame_count = 0, active pattern = 0, and registered outputs to vga_blank = 1, rgb = 0, syncs inactive, frame_start = 0.
REQ-032 Reset mid-frame SHALL take priority over enable and counter advance; first post-reset cycle decodes pixel (0,0) and latches pattern_sel.

Verification
REQ-033 Defaults, enable = 1, run 2 frames -> hsync low 96 cycles every 800, vsync low 2 lines every 525, blank low 640x480 pixels per frame, frame_start period 420000 cycles.
REQ-034 pattern_sel = 1 -> pixel 0 = (FF,FF,FF), pixel 80 = (FF,FF,00), pixel 639 = (00,00,00), pixel 640 = 0 with blank = 1.
REQ-035 pattern_sel changed 1→2 at line 100 -> frame unchanged until next frame_start; next frame pixel (32,0) = white, (32,32) = black.
REQ-036 enable dropped for 50 cycles mid-line -> blank = 1, syncs inactive, counters resume at same hcnt; frame period grows by exactly 50 cycles.
REQ-037 resetn pulsed low mid-frame with pattern 3 -> outputs reset values next cycle; frame_count = 0; after release first frame_start exactly 1 cycle after first enabled edge.
REQ-038 Force 65536 frames (or preset-free long run with small params, e.g. H_ACTIVE=8, all porches 1, V_ACTIVE=2) -> frame_count wraps 0xFFFF→0x0000.
